// File: rtl/i2c_xfer_seq_if.sv
// Host and i2c_master signals of the register-transfer sequencer.
// slave: sequencer view; master: host/bus-model view.
interface i2c_xfer_seq_if #(
  parameter int LEN_W = 4
);
  // host side
  logic             req;
  logic             busy;
  logic             rnw;
  logic [6:0]       dev;
  logic [7:0]       regp;
  logic [LEN_W-1:0] len;
  logic [7:0]       wdat;
  logic             wdat_rdy;
  logic [7:0]       rdat;
  logic             rdat_vld;
  logic             done;
  logic [1:0]       err;
  // byte-level i2c_master side
  logic [4:0]       m_cmd;
  logic [7:0]       m_dat;
  logic             m_ws;
  logic [6:0]       m_stat;
  logic [7:0]       m_dat_in;

  modport slave (
    input  req, rnw, dev, regp, len, wdat, m_stat, m_dat_in,
    output busy, wdat_rdy, rdat, rdat_vld, done, err, m_cmd, m_dat, m_ws
  );

  modport master (
    output req, rnw, dev, regp, len, wdat, m_stat, m_dat_in,
    input  busy, wdat_rdy, rdat, rdat_vld, done, err, m_cmd, m_dat, m_ws
  );
endinterface

// File: rtl/i2c_xfer_seq.sv
// Register-transfer sequencer: expands one host request into the
// i2c_master command stream, checks each status word, aborts on failure
// and reports read bytes plus a completion code.
module i2c_xfer_seq #(
  parameter int LEN_W = 4
) (
  input logic           clk,
  input logic           rst,   // active-low, asynchronous
  i2c_xfer_seq_if.slave bus
);
  // master command bits
  localparam logic [4:0] C_STRT = 5'h01;
  localparam logic [4:0] C_STOP = 5'h02;
  localparam logic [4:0] C_READ = 5'h04;
  localparam logic [4:0] C_WRTE = 5'h08;
  localparam logic [4:0] C_NACK = 5'h10;

  // command-list phases; data phase repeats under the byte counter
  localparam logic [1:0] PH_ADDR  = 2'd0;
  localparam logic [1:0] PH_PTR   = 2'd1;
  localparam logic [1:0] PH_RADDR = 2'd2;
  localparam logic [1:0] PH_DATA  = 2'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, AWAIT, FIN} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       phase_reg, phase_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic             rnw_reg, rnw_next;
  logic [6:0]       dev_reg, dev_next;
  logic [7:0]       regp_reg, regp_next;
  logic [1:0]       err_reg, err_next;
  logic [7:0]       rdat_reg, rdat_next;
  logic             vld_reg, vld_next;

  logic       cmd_last, cmd_read;
  logic [4:0] cmd_word;
  logic [7:0] cmd_dat;

  // master status fields
  logic st_err, st_alo, st_bbl, st_ack, st_bsy;
  assign st_err = bus.m_stat[1];
  assign st_alo = bus.m_stat[2];
  assign st_bbl = bus.m_stat[3];
  assign st_ack = bus.m_stat[4];
  assign st_bsy = bus.m_stat[5];

  // DON and BBY carry no extra information once BSY has dropped
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.m_stat[6], bus.m_stat[0]};

  // a write with len=0 ends on the pointer byte; otherwise the final
  // data byte (counter==1) closes the list
  assign cmd_last = (phase_reg == PH_PTR && !rnw_reg && cnt_reg == '0) ||
                    (phase_reg == PH_DATA && cnt_reg == LEN_W'(1));
  assign cmd_read = (phase_reg == PH_DATA) && rnw_reg;

  // command word and byte for the current list position
  always_comb begin
    cmd_word = C_WRTE;
    cmd_dat  = 8'h00;
    case (phase_reg)
      PH_ADDR:  begin cmd_word = C_STRT | C_WRTE; cmd_dat = {dev_reg, 1'b0}; end
      PH_PTR:   begin cmd_word = C_WRTE;          cmd_dat = regp_reg;        end
      PH_RADDR: begin cmd_word = C_STRT | C_WRTE; cmd_dat = {dev_reg, 1'b1}; end
      default: begin
        if (rnw_reg) begin cmd_word = C_READ; cmd_dat = 8'hFF;    end
        else         begin cmd_word = C_WRTE; cmd_dat = bus.wdat; end
      end
    endcase
    if (cmd_last) cmd_word = cmd_word | C_STOP | (cmd_read ? C_NACK : 5'h00);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      phase_reg <= PH_ADDR;
      cnt_reg   <= '0;
      rnw_reg   <= 1'b0;
      dev_reg   <= 7'h00;
      regp_reg  <= 8'h00;
      err_reg   <= 2'd0;
      rdat_reg  <= 8'h00;
      vld_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      rnw_reg   <= rnw_next;
      dev_reg   <= dev_next;
      regp_reg  <= regp_next;
      err_reg   <= err_next;
      rdat_reg  <= rdat_next;
      vld_reg   <= vld_next;
    end
  end

  // next-state logic and strobe outputs
  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    cnt_next     = cnt_reg;
    rnw_next     = rnw_reg;
    dev_next     = dev_reg;
    regp_next    = regp_reg;
    err_next     = err_reg;
    rdat_next    = rdat_reg;
    vld_next     = 1'b0;
    bus.m_cmd    = 5'h00;
    bus.m_dat    = 8'h00;
    bus.m_ws     = 1'b0;
    bus.wdat_rdy = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = (state_reg != IDLE) && (state_reg != FIN);
    case (state_reg)
      IDLE: begin
        if (bus.req && !st_bsy) begin
          rnw_next   = bus.rnw;
          dev_next   = bus.dev;
          regp_next  = bus.regp;
          cnt_next   = bus.len;
          phase_next = PH_ADDR;
          if (bus.rnw && bus.len == '0) begin
            err_next   = 2'd3;     // zero-length read: nothing to do
            state_next = FIN;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        bus.m_cmd    = cmd_word;
        bus.m_dat    = cmd_dat;
        bus.m_ws     = 1'b1;
        bus.wdat_rdy = (phase_reg == PH_DATA) && !rnw_reg;
        state_next   = WAIT;
      end
      WAIT: begin
        if (!st_bsy) begin
          if (st_err && st_alo) begin
            err_next = 2'd2; state_next = FIN;
          end else if (st_err && st_bbl) begin
            err_next = 2'd3; state_next = FIN;
          end else if (st_err) begin
            err_next = 2'd3; state_next = ABORT;
          end else if (!cmd_read && !st_ack) begin
            err_next   = 2'd1;
            state_next = cmd_last ? FIN : ABORT;  // STOP already sent?
          end else begin
            if (cmd_read) begin
              rdat_next = bus.m_dat_in;
              vld_next  = 1'b1;
            end
            if (cmd_last) begin
              err_next   = 2'd0;
              state_next = FIN;
            end else begin
              state_next = ISSUE;
              case (phase_reg)
                PH_ADDR:  phase_next = PH_PTR;
                PH_PTR:   phase_next = rnw_reg ? PH_RADDR : PH_DATA;
                PH_RADDR: phase_next = PH_DATA;
                default:  cnt_next   = cnt_reg - LEN_W'(1);
              endcase
            end
          end
        end
      end
      ABORT: begin
        bus.m_cmd  = C_STOP;
        bus.m_ws   = 1'b1;
        state_next = AWAIT;
      end
      AWAIT: begin
        if (!st_bsy) state_next = FIN;
      end
      default: begin  // FIN
        bus.done   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.err      = err_reg;
  assign bus.rdat     = rdat_reg;
  assign bus.rdat_vld = vld_reg;
endmodule
